present_round_datapath: RTL and testbench
=========================================

// Module: present_round_datapath
// PURPOSE
//  PRESENT-80 encryption datapath and the consumer of the round-key stream.
//  - Upstream key-schedule stage supplies round keys K1..K32 one per handshake.
//  - Iterates addRoundKey -> sBoxLayer -> pLayer for ROUNDS rounds.
//  - Whitens with the final key and presents the ciphertext with a one-cycle done pulse.
// PARAMETERS
//  ROUNDS  31  full rounds before final whitening; legal 1..62; total keys consumed = ROUNDS+1
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high; clears all state
//  start       in   1   load plaintext, begin encryption; honoured only when busy=0
//  plaintext   in   64  block to encrypt; sampled on accepted start
//  round_key   in   64  current round key (bits 79:16 of key register)
//  rk_valid    in   1   round_key valid
//  rk_ready    out  1   datapath accepts round_key this cycle
//  rk_index    out  6   1-based index of the key expected next (1..ROUNDS+1)
//  busy        out  1   encryption in progress
//  ciphertext  out  64  result; holds until next completion or reset
//  done        out  1   one-cycle pulse, ciphertext valid
// BEHAVIOUR
//  - Reset values: state=0, cnt=0, ciphertext=0, done=0, busy=0, rk_ready=0, rk_index=1.
//  - FSM IDLE:
//    - start=1 -> state<=plaintext, cnt<=1, go RUN.
//    - Otherwise hold.
//  - FSM RUN:
//    - rk_ready=1 and busy=1; a key is accepted when rk_valid and rk_ready are both 1.
//    - Accepted key with cnt<=ROUNDS: state <= P(S(state ^ round_key)), cnt++.
//    - Accepted key with cnt==ROUNDS+1: ciphertext <= state ^ round_key, done=1 next cycle,
//      go IDLE.
//    - No accepted key: hold state, no timeout.
//  - S-box (nibble-wise, x->S[x]): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
//  - pLayer: bit i -> bit (16*i mod 63) for i<63; bit 63 -> 63.
//  - rk_index = cnt, combinational from the registered counter; bench checks it per handshake.
//  - Latency: ROUNDS+1 accepted keys after start; back-to-back valid gives done
//    ROUNDS+2 cycles after start.
//  - done is registered, high exactly one cycle, and coincides with busy returning to 0.
//  - start while busy=1 is ignored, including the cycle of the last key; no queuing.
//  - start in the cycle after done is accepted, so back-to-back blocks are legal.
//  - Reset asserted mid-encryption aborts:
//    - the partial state is lost and done is not produced;
//    - ciphertext returns to 0.
//  - plaintext may change after the start cycle without effect.
// CONFIGURATION
//  PRESENT_DP_TRACE_EN defined:
//    - adds outputs dbg_state[63:0] (current state register) and dbg_round[5:0] (cnt);
//    - both are reset to 0;
//    - both are updated in the same edge as the state.
//  PRESENT_DP_TRACE_EN undefined:
//    - ports absent; functional behaviour identical.
// TESTING
//  - Key schedule model, key=0, plaintext=0, keys back-to-back
//    -> ciphertext=5579C1387B228445, done at cycle 33 after start.
//  - key=0, plaintext=FFFFFFFFFFFFFFFF -> ciphertext=A112FFC72F68417B.
//  - key=FFFFFFFFFFFFFFFFFFFF, plaintext=0, rk_valid randomly throttled 50%
//    -> ciphertext=E72C46C0F5945049, exactly 32 handshakes, rk_index 1..32 in order.
//  - start pulsed at rounds 5 and 32 -> ignored; result unchanged.
//  - Second start the cycle after done -> second vector correct.
//  - reset asserted at round 17 -> busy=0, done never pulses, ciphertext=0;
//    a new start then yields the correct result.
//  - With PRESENT_DP_TRACE_EN: dbg_round tracks rk_index.
//  - With PRESENT_DP_TRACE_EN, key=0, plaintext=0: dbg_state after round 1 = P(S(0)) = FFFFFFFF00000000.

Source files
------------

// File: rtl/present_round_datapath.sv
// present_round_datapath: PRESENT-80 encryption datapath fed by an external round-key stream.
// Each accepted key performs addRoundKey -> sBoxLayer -> pLayer. The key after the last
// round whitens the state into the ciphertext. Define PRESENT_DP_TRACE_EN to expose
// dbg_state and dbg_round.
module present_round_datapath #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [63:0] round_key,
  input  logic        rk_valid,
  output logic        rk_ready,
  output logic [5:0]  rk_index,
  output logic        busy,
  output logic [63:0] ciphertext,
  output logic        done
`ifdef PRESENT_DP_TRACE_EN
  ,
  output logic [63:0] dbg_state,
  output logic [5:0]  dbg_round
`endif
);

  // Counter value at which the incoming key is the whitening key.
  localparam logic [5:0] LastCnt = 6'(ROUNDS + 1);

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] ct_q, ct_d;
  logic        done_q, done_d;
  logic        key_acc;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  base;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      base = 6'(4 * n);
      y[base +: 4] = sbox(x[base +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  src;
    logic [5:0]  dst;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      src    = 6'(i);
      dst    = 6'((16 * i) % 63);
      y[dst] = x[src];
    end
    y[63] = x[63];
    return y;
  endfunction

  assign key_acc = (fsm_q == StRun) && rk_valid;

  // Next-state logic: load on start, one round per accepted key, whiten on the final key.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      StIdle: begin
        if (start) begin
          state_d = plaintext;
          cnt_d   = 6'd1;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        if (key_acc) begin
          if (cnt_q == LastCnt) begin
            ct_d   = state_q ^ round_key;
            done_d = 1'b1;
            cnt_d  = 6'd0;
            fsm_d  = StIdle;
          end else begin
            state_d = p_layer(s_layer(state_q ^ round_key));
            cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // All state registers; reset aborts any encryption in flight and clears the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (fsm_q == StRun);
  assign rk_ready   = (fsm_q == StRun);
  // Counter idles at 0 but the next key expected is always at least K1.
  assign rk_index   = (cnt_q == 6'd0) ? 6'd1 : cnt_q;
  assign ciphertext = ct_q;
  assign done       = done_q;

`ifdef PRESENT_DP_TRACE_EN
  assign dbg_state = state_q;
  assign dbg_round = cnt_q;
`endif

endmodule

// File: tb/tb_present_round_datapath.sv
// Self-checking bench for present_round_datapath: behavioural PRESENT-80 model with its own
// key schedule, per-cycle comparison of outputs, plus literal test vectors.
module tb_present_round_datapath;

  localparam int unsigned ROUNDS = 31;
  localparam int          NK     = ROUNDS + 1;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] round_key;
  logic        rk_valid;
  logic        rk_ready;
  logic [5:0]  rk_index;
  logic        busy;
  logic [63:0] ciphertext;
  logic        done;
`ifdef PRESENT_DP_TRACE_EN
  logic [63:0] dbg_state;
  logic [5:0]  dbg_round;
`endif

  int n_checks = 0;
  int n_err    = 0;

  present_round_datapath #(
    .ROUNDS(ROUNDS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .plaintext (plaintext),
    .round_key (round_key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .busy      (busy),
    .ciphertext(ciphertext),
    .done      (done)
`ifdef PRESENT_DP_TRACE_EN
    ,
    .dbg_state (dbg_state),
    .dbg_round (dbg_round)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // S-box as a packed table, S[0] in the low nibble.
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  // Reference cipher: full key schedule and rounds; pLayer via its inverse (j <- 4*j mod 63).
  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    logic [5:0]  b;
    logic [5:0]  src;
    logic [5:0]  dst;
    k = key;
    s = pt;
    for (int r = 1; r <= int'(ROUNDS); r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) begin
        b         = 6'(4 * n);
        t[b +: 4] = sb(s[b +: 4]);
      end
      for (int j = 0; j < 63; j++) begin
        dst    = 6'(j);
        src    = 6'((4 * j) % 63);
        s[dst] = t[src];
      end
      s[63]     = t[63];
      k         = {k[18:0], k[79:19]};
      k[79:76]  = sb(k[79:76]);
      k[19:15]  = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Round-key table K1..K(NK) for the cipher key of the current block.
  logic [63:0] rk_tab [1:NK];
  logic [79:0] cur_key  = '0;
  bit          throttle = 1'b0;

  task automatic gen_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 1; r <= NK; r++) begin
      rk_tab[r] = k[79:16];
      k         = {k[18:0], k[79:19]};
      k[79:76]  = sb(k[79:76]);
      k[19:15]  = k[19:15] ^ 5'(r);
    end
  endtask

  // Transaction-level model of the block's observable behaviour.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_ct   = '0;
  logic [63:0] m_pt   = '0;
  int          m_hs   = 0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ct   = '0;
        m_hs   = 0;
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (start) begin
            m_busy = 1'b1;
            m_pt   = plaintext;
            m_hs   = 0;
          end
        end else if (rk_valid) begin
          m_hs++;
          if (m_hs == NK) begin
            m_ct   = present_enc(m_pt, cur_key);
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Upstream key-schedule stage: presents the key the model expects next.
  initial begin
    int idx;
    rk_valid  = 1'b0;
    round_key = '0;
    forever begin
      @(posedge clock);
      #1;
      rk_valid = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      idx      = m_busy ? m_hs + 1 : 1;
      if (idx > NK) idx = NK;
      round_key = rk_tab[idx];
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("rk_ready", 64'(rk_ready), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("ciphertext", ciphertext, m_ct);
      if (m_busy) chk("rk_index", 64'(rk_index), 64'(m_hs + 1));
`ifdef PRESENT_DP_TRACE_EN
      if (m_busy) chk("dbg_round", 64'(dbg_round), 64'(rk_index));
      if (m_busy && m_hs == 1 && cur_key == 80'd0 && m_pt == 64'd0)
        chk("dbg_state_round1", dbg_state, 64'hFFFF_FFFF_0000_0000);
`endif
    end
  end

  // One encryption; optional ignored start pulses, optional mid-run reset, literal checks.
  task automatic run_block(input logic [79:0] key, input logic [63:0] pt, input bit thr,
                           input int s1, input int s2, input int rst_at,
                           input bit use_lit, input logic [63:0] lit, input int exp_lat);
    int cyc;
    int hs;
    int limit;
    bit got;
    gen_keys(key);
    cur_key  = key;
    throttle = thr;
    @(posedge clock);
    #1;
    start     = 1'b1;
    plaintext = pt;
    @(posedge clock);
    #1;
    cyc   = 1;
    hs    = 0;
    got   = 1'b0;
    limit = (rst_at > 0) ? rst_at + 40 : 300;
    while (!got && cyc < limit) begin
      start     = (cyc == s1) || (cyc == s2);
      plaintext = {$urandom, $urandom};
      if (cyc == rst_at) reset = 1'b1;
      @(negedge clock);
      if (rk_valid && rk_ready) begin
        chk("rk_index_order", 64'(rk_index), 64'(hs + 1));
        hs++;
      end
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc++;
      end
    end
    start = 1'b0;
    if (rst_at > 0) begin
      chk("no_done_after_reset", 64'(got), 64'd0);
      chk("ciphertext_after_reset", ciphertext, 64'd0);
      chk("busy_after_reset", 64'(busy), 64'd0);
    end else begin
      chk("done_seen", 64'(got), 64'd1);
      chk("handshakes", 64'(hs), 64'(NK));
      if (use_lit) chk("ciphertext_vector", ciphertext, lit);
      if (exp_lat > 0) chk("done_latency", 64'(cyc), 64'(exp_lat));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before t=400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [79:0] rkey;
    logic [63:0] rpt;
    reset     = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rk_ready", 64'(rk_ready), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ciphertext", ciphertext, 64'd0);
    chk("reset_rk_index", 64'(rk_index), 64'd1);
`ifdef PRESENT_DP_TRACE_EN
    chk("reset_dbg_state", dbg_state, 64'd0);
    chk("reset_dbg_round", 64'(dbg_round), 64'd0);
`endif
    // Pin the reference model to the published vectors.
    chk("model_k0_p0", present_enc(64'd0, 80'd0), 64'h5579_C138_7B22_8445);
    chk("model_k0_p1", present_enc({64{1'b1}}, 80'd0), 64'hA112_FFC7_2F68_417B);
    chk("model_k1_p0", present_enc(64'd0, {80{1'b1}}), 64'hE72C_46C0_F594_5049);
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_block(80'd0, 64'd0, 1'b0, 0, 0, 0, 1'b1, 64'h5579_C138_7B22_8445, ROUNDS + 2);
    // Back-to-back block, with starts during round 5 and during the last key.
    run_block(80'd0, {64{1'b1}}, 1'b0, 5, 32, 0, 1'b1, 64'hA112_FFC7_2F68_417B, ROUNDS + 2);
    run_block({80{1'b1}}, 64'd0, 1'b1, 0, 0, 0, 1'b1, 64'hE72C_46C0_F594_5049, 0);
    rkey = {$urandom, $urandom, 16'($urandom)};
    rpt  = {$urandom, $urandom};
    run_block(rkey, rpt, 1'b0, 0, 0, 17, 1'b0, 64'd0, 0);
    run_block({80{1'b1}}, 64'd0, 1'b0, 0, 0, 0, 1'b1, 64'hE72C_46C0_F594_5049, ROUNDS + 2);
    for (int b = 0; b < 6; b++) begin
      rkey = {$urandom, $urandom, 16'($urandom)};
      rpt  = {$urandom, $urandom};
      run_block(rkey, rpt, ($urandom_range(0, 1) == 1), 0, 0, 0, 1'b0, 64'd0, 0);
    end
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
